mor1kx_ibus_wb_espresso: RTL and testbench

Instruction-bus bridge directly upstream of the espresso fetch unit. Converts the fetch unit's req/adr/ack/err ibus handshake into Wishbone B3 classic single reads. Holds each Wishbone cycle until the slave terminates it, safely discards responses the fetch unit no longer wants (after a branch or restart), and reports a bus error on slave error or timeout.

---
 rtl/mor1kx_ibus_wb_espresso_pkg.sv | 19 +
 rtl/mor1kx_ibus_wb_espresso_if.sv | 30 +++
 rtl/mor1kx_bus_timeout.sv | 33 +++
 rtl/mor1kx_ibus_wb_espresso.sv | 129 ++++++++++++
 tb/tb_mor1kx_ibus_wb_espresso.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mor1kx_ibus_wb_espresso_pkg.sv
// Shared definitions for the espresso instruction-bus Wishbone bridge:
// FSM encoding, constant Wishbone cycle attributes and the OR1K NOP opcode.
package mor1kx_ibus_wb_espresso_pkg;

  localparam logic [5:0]  OR1K_OPCODE_NOP = 6'h05;
  localparam logic [31:0] OR1K_NOP_INSN   = {OR1K_OPCODE_NOP, 26'd0};

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
  localparam logic [3:0] WB_SEL_WORD    = 4'hf;

  typedef enum logic [1:0] {
    IBUS_IDLE  = 2'd0,
    IBUS_READ  = 2'd1,
    IBUS_RETRY = 2'd2,
    IBUS_DRAIN = 2'd3
  } ibus_state_t;

endpackage

// File: rtl/mor1kx_ibus_wb_espresso_if.sv
// Wishbone B3 classic read bus between the ibus bridge (master) and memory (slave).
interface mor1kx_ibus_wb_espresso_if #(
  parameter int AW = 32
);
  // Handshake: cyc/stb high opens a read of adr; the slave closes it by raising
  // one of ack/err/rty for one cycle while cyc is high. Responses seen while
  // cyc is low carry no meaning and are ignored by the master.
  logic [AW-1:0] adr;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [31:0]   dat;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output adr, cyc, stb, we, sel, cti, bte,
    input  dat, ack, err, rty
  );

  modport slave (
    input  adr, cyc, stb, we, sel, cti, bte,
    output dat, ack, err, rty
  );

endinterface

// File: rtl/mor1kx_bus_timeout.sv
// Saturating cycle counter that flags a bus cycle left open too long.
// TIMEOUT_CYCLES of 0 disables the expiry flag entirely.
module mor1kx_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + TIMEOUT_WIDTH'(1);
    end
  end

  // Fires during the last permitted cycle so the owner can close the cycle
  // on that edge: the bus stays open exactly TIMEOUT_CYCLES cycles.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/mor1kx_ibus_wb_espresso.sv
// Espresso fetch-unit ibus to Wishbone classic single-read bridge with
// cancel/drain of unwanted responses, retry handling and cycle timeout.
module mor1kx_ibus_wb_espresso
  import mor1kx_ibus_wb_espresso_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 255,
  parameter int TIMEOUT_WIDTH        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_i,
  input  logic                            cpu_burst_i,
  output logic                            cpu_ack_o,
  output logic                            cpu_err_o,
  output logic [31:0]                     cpu_dat_o,
  mor1kx_ibus_wb_espresso_if.master       wbm,
  output ibus_state_t                     dbg_state
);

  ibus_state_t                     state, state_n;
  logic                            cyc_q, cyc_n;
  logic [OPTION_OPERAND_WIDTH-1:0] adr_q, adr_n;
  logic [31:0]                     dat_n;
  logic                            ack_n, err_n;
  logic                            terminate, cancel, expired;
  logic                            unused_burst;

  // Every fetch is a single classic read; the burst hint carries no meaning here.
  assign unused_burst = cpu_burst_i;

  assign terminate = cyc_q & (wbm.ack | wbm.err | wbm.rty);
  assign cancel    = !cpu_req_i || (cpu_adr_i != adr_q);

  mor1kx_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!cyc_q),
    .enable  (cyc_q && !terminate),
    .expired (expired)
  );

  always_comb begin
    state_n = state;
    cyc_n   = cyc_q;
    adr_n   = adr_q;
    dat_n   = cpu_dat_o;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      // The pulse gate gives the fetch unit a cycle to move its PC first.
      IBUS_IDLE: begin
        if (cpu_req_i && !cpu_ack_o && !cpu_err_o) begin
          adr_n   = cpu_adr_i;
          cyc_n   = 1'b1;
          state_n = IBUS_READ;
        end
      end
      IBUS_READ: begin
        if (terminate) begin
          cyc_n   = 1'b0;
          state_n = IBUS_IDLE;
          if (!cancel) begin
            if (wbm.err) begin
              err_n = 1'b1;
            end else if (wbm.ack) begin
              ack_n = 1'b1;
              dat_n = wbm.dat;
            end else begin
              state_n = IBUS_RETRY;
            end
          end
        end else if (expired) begin
          cyc_n   = 1'b0;
          state_n = IBUS_IDLE;
          err_n   = !cancel;
        end else if (cancel) begin
          state_n = IBUS_DRAIN;
        end
      end
      IBUS_RETRY: begin
        cyc_n   = 1'b1;
        state_n = IBUS_READ;
      end
      IBUS_DRAIN: begin
        if (terminate || expired) begin
          cyc_n   = 1'b0;
          state_n = IBUS_IDLE;
        end
      end
      default: begin
        cyc_n   = 1'b0;
        state_n = IBUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IBUS_IDLE;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      cpu_ack_o <= 1'b0;
      cpu_err_o <= 1'b0;
      cpu_dat_o <= OR1K_NOP_INSN;
    end else begin
      state     <= state_n;
      cyc_q     <= cyc_n;
      adr_q     <= adr_n;
      cpu_ack_o <= ack_n;
      cpu_err_o <= err_n;
      cpu_dat_o <= dat_n;
    end
  end

  assign wbm.adr   = adr_q;
  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;
  assign wbm.we    = 1'b0;
  assign wbm.sel   = WB_SEL_WORD;
  assign wbm.cti   = WB_CTI_CLASSIC;
  assign wbm.bte   = WB_BTE_LINEAR;
  assign dbg_state = state;

endmodule

// File: tb/tb_mor1kx_ibus_wb_espresso.sv
// Scoreboard bench: fetch-unit driver, planned Wishbone slave, response monitor.
module tb_mor1kx_ibus_wb_espresso;
  import mor1kx_ibus_wb_espresso_pkg::*;

  localparam logic [31:0] NOP = 32'h1400_0000;
  localparam int R_ACK = 0, R_ERR = 1, R_RTY = 2, R_SILENT = 3, R_ABORT = 4;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_SILENT = 3;
  localparam int TMO = 4;

  typedef struct {
    logic [31:0] adr;
    int          resp;
    int          wait_n;
    logic [31:0] data;
  } plan_t;

  logic        clk, rst;
  logic        cpu_req, cpu_burst;
  logic [31:0] cpu_adr;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_dat;
  ibus_state_t dbg_state;

  mor1kx_ibus_wb_espresso_if #(.AW(32)) wbm ();

  mor1kx_ibus_wb_espresso #(
    .OPTION_OPERAND_WIDTH (32),
    .TIMEOUT_CYCLES       (TMO),
    .TIMEOUT_WIDTH        (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_i   (cpu_req),
    .cpu_adr_i   (cpu_adr),
    .cpu_burst_i (cpu_burst),
    .cpu_ack_o   (cpu_ack),
    .cpu_err_o   (cpu_err),
    .cpu_dat_o   (cpu_dat),
    .wbm         (wbm),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  plan_t       plan_q[$];
  logic [31:0] model_dat = NOP;
  int          exp_rise = -1;
  int          last_pulse_cyc = 0;
  int          resp_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // ---------------- Wishbone slave following the plan queue ----------------
  initial begin
    plan_t cur;
    bit    active, responded, dummy;
    int    cnt, high;
    active = 0; responded = 0; dummy = 0; cnt = 0; high = 0;
    wbm.ack = 1'b0; wbm.err = 1'b0; wbm.rty = 1'b0; wbm.dat = '0;
    forever begin
      @(posedge clk); #1;
      wbm.ack = 1'b0; wbm.err = 1'b0; wbm.rty = 1'b0;
      if (active && responded) begin
        chk("cyc_drop_after_term", wbm.cyc, 1'b0);
        active = 0;
      end else if (active && !wbm.cyc) begin
        if (cur.resp == R_SILENT && !dummy) chk("timeout_len", high, TMO);
        active = 0;
      end
      if (!active && wbm.cyc) begin
        dummy = (plan_q.size() == 0);
        chk("planned_cycle", dummy, 1'b0);
        if (dummy) begin
          cur.adr = '0; cur.resp = R_ABORT; cur.wait_n = 0; cur.data = '0;
        end else begin
          cur = plan_q.pop_front();
          chk("wb_adr_issue", wbm.adr, cur.adr);
        end
        if (exp_rise >= 0) begin
          chk("cyc_latency", cyc_no, exp_rise);
          exp_rise = -1;
        end
        active = 1; responded = 0; cnt = cur.wait_n; high = 0;
      end
      if (active) begin
        high++;
        if (!dummy) chk("wb_adr_hold", wbm.adr, cur.adr);
        if (cnt > 0) begin
          cnt--;
        end else if (cur.resp <= R_RTY && !responded) begin
          responded = 1;
          case (cur.resp)
            R_ACK:   begin wbm.ack = 1'b1; wbm.dat = cur.data; end
            R_ERR:   begin wbm.err = 1'b1; wbm.dat = $urandom(); end
            default: begin wbm.rty = 1'b1; exp_rise = cyc_no + 2; end
          endcase
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // stray response with no cycle open
        wbm.ack = 1'b1;
        wbm.dat = $urandom();
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit          prev_pulse, pulse;
    logic [32:0] e;
    prev_pulse = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pulse = 0;
        continue;
      end
      chk("stb_eq_cyc", wbm.stb, wbm.cyc);
      chk("we_const", wbm.we, 1'b0);
      chk("sel_cti_bte", {wbm.sel, wbm.cti, wbm.bte}, {4'hf, 3'b000, 2'b00});
      pulse = cpu_ack | cpu_err;
      if (pulse) begin
        chk("ack_err_exclusive", cpu_ack & cpu_err, 1'b0);
        chk("pulse_gap", prev_pulse, 1'b0);
        chk("resp_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("resp_kind_err", cpu_err, e[32]);
          chk("resp_dat", cpu_dat, e[31:0]);
        end
        resp_cnt++;
        last_pulse_cyc = cyc_no;
      end
      prev_pulse = pulse;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_resp(input int n0);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #2;
      if (resp_cnt != n0) got = 1;
    end
    chk("resp_arrived", resp_cnt, n0 + 1);
    if (!got) cpu_req = 1'b0;
  endtask

  task automatic wait_cyc();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #2;
      if (wbm.cyc) got = 1;
    end
    chk("cyc_opened", wbm.cyc, 1'b1);
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] adr, input int kind, input int wait_n,
                       input bit b2b, input logic [31:0] d);
    plan_t p;
    int    n0;
    if (wait_n < 0) wait_n = $urandom_range(0, 2);
    if (kind == K_RTY) begin
      p.adr = adr; p.resp = R_RTY; p.wait_n = $urandom_range(0, 2); p.data = '0;
      plan_q.push_back(p);
    end
    p.adr = adr; p.wait_n = wait_n; p.data = d;
    case (kind)
      K_ERR:    p.resp = R_ERR;
      K_SILENT: p.resp = R_SILENT;
      default:  p.resp = R_ACK;
    endcase
    plan_q.push_back(p);
    if (p.resp == R_ACK) begin
      exp_q.push_back({1'b0, d});
      model_dat = d;
    end else begin
      exp_q.push_back({1'b1, model_dat});
    end
    exp_rise = b2b ? last_pulse_cyc + 2 : cyc_no + 1;
    n0 = resp_cnt;
    cpu_adr = adr;
    cpu_req = 1'b1;
    wait_resp(n0);
  endtask

  task automatic fetch_cancel(input logic [31:0] old_adr, input logic [31:0] new_adr,
                              input int old_resp, input bit b2b);
    plan_t       p;
    logic [31:0] d;
    int          n0;
    d = $urandom();
    p.adr = old_adr; p.resp = old_resp; p.wait_n = $urandom_range(0, 3); p.data = $urandom();
    plan_q.push_back(p);
    p.adr = new_adr; p.resp = R_ACK; p.wait_n = $urandom_range(0, 2); p.data = d;
    plan_q.push_back(p);
    exp_q.push_back({1'b0, d});
    model_dat = d;
    exp_rise = b2b ? last_pulse_cyc + 2 : cyc_no + 1;
    n0 = resp_cnt;
    cpu_adr = old_adr;
    cpu_req = 1'b1;
    wait_cyc();
    cpu_adr = new_adr;
    wait_resp(n0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cyc"}, wbm.cyc, 1'b0);
    chk({tag, "_stb"}, wbm.stb, 1'b0);
    chk({tag, "_adr"}, wbm.adr, 32'h0);
    chk({tag, "_ack"}, cpu_ack, 1'b0);
    chk({tag, "_err"}, cpu_err, 1'b0);
    chk({tag, "_dat"}, cpu_dat, NOP);
    chk({tag, "_state"}, dbg_state, IBUS_IDLE);
  endtask

  task automatic reset_mid_cycle(input logic [31:0] adr);
    plan_t p;
    p.adr = adr; p.resp = R_ABORT; p.wait_n = 0; p.data = '0;
    plan_q.push_back(p);
    exp_rise = -1;
    cpu_adr = adr;
    cpu_req = 1'b1;
    wait_cyc();
    @(negedge clk); #2;
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_dat = NOP;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    chk("no_resp_after_rst", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          r, k;
    bit          held;
    logic [31:0] a;
    rst = 1'b1; cpu_req = 1'b0; cpu_adr = '0; cpu_burst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    fetch(32'h100, K_ACK, 2, 1'b0, 32'h1500_0000);
    fetch(32'h104, K_ACK, 0, 1'b1, 32'h1500_0001);
    fetch_cancel(32'h108, 32'h2000, R_ACK, 1'b1);
    idle(2);
    fetch(32'h300, K_ERR, 1, 1'b0, 32'hdead_beef);
    idle(1);
    fetch(32'h400, K_RTY, 1, 1'b0, 32'h1234_5678);
    fetch(32'h500, K_SILENT, 0, 1'b1, 32'h0);
    idle(2);
    reset_mid_cycle(32'h600);
    idle(1);

    held = 0;
    for (int i = 0; i < 48; i++) begin
      r = $urandom_range(0, 11);
      a = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
      cpu_burst = 1'($urandom_range(0, 1));
      if (r == 0) begin
        k = $urandom_range(0, 2);
        fetch_cancel(a, a ^ 32'h1000, (k == 0) ? R_ACK : ((k == 1) ? R_ERR : R_SILENT), held);
      end else begin
        k = (r <= 6) ? K_ACK : ((r == 7) ? K_ERR : ((r <= 9) ? K_RTY : K_SILENT));
        fetch(a, k, -1, held, $urandom());
      end
      held = 1'($urandom_range(0, 1));
      if (!held) idle($urandom_range(1, 3));
    end
    idle(8);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("plan_q_drained", plan_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
